// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types: execution engine select, exec-stage states, defaults
// Imported by core_exec_ctrl and core_exec_watchdog.
package core_pkg;

   typedef enum logic [1:0] {
      EXEC_ALU = 2'd0,
      EXEC_MUL = 2'd1,
      EXEC_LSU = 2'd2,
      EXEC_CSR = 2'd3
   } exec_engine_e;

   typedef enum logic {
      EXEC_IDLE     = 1'b0,
      EXEC_MUL_WAIT = 1'b1
   } exec_ctrl_state_e;

   localparam int EXEC_MUL_TIMEOUT = 64;
   localparam int EXEC_DATA_W      = 32;

endpackage

// File: rtl/core_exec_watchdog.sv
// rtl/core_exec_watchdog.sv - multiplier watchdog: wait-cycle counter, expiry compare, sticky error
// The counter runs only while the sequencer waits on the multiplier and restarts from 0 on every wait.
module core_exec_watchdog
   import core_pkg::*;
#(
   parameter int MUL_TIMEOUT = EXEC_MUL_TIMEOUT,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic abort,
   output logic timeout,
   output logic err_timeout
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Expiry is the cycle the counter would step to MUL_TIMEOUT; a coincident done or flush wins.
   assign timeout     = run && !abort && (cnt_q == CNT_W'(MUL_TIMEOUT - 1));
   assign err_timeout = err_q;

   always_comb begin
      cnt_d = '0;
      err_d = err_q || timeout;
      if (run && !abort && !timeout) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

endmodule

// File: rtl/core_exec_ctrl.sv
// rtl/core_exec_ctrl.sv - execute-stage sequencer dispatching ops to the ALU or multi-cycle multiplier
// Multiplier path, watchdog, mul_start and mul_kill exist only with CORE_EXEC_MUL_EN defined.
module core_exec_ctrl
   import core_pkg::*;
#(
   parameter int MUL_TIMEOUT = EXEC_MUL_TIMEOUT,
   parameter int CNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  exec_engine_e       exec_engine,
   input  logic [31:0]        alu_result,
   output logic               mul_start,
   output logic               mul_kill,
   input  logic               mul_done,
   input  logic [31:0]        mul_result,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_result,
   output logic               out_illegal,
   output logic               err_timeout
);

   exec_ctrl_state_e state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_result_q, out_result_d;
   logic             out_illegal_q, out_illegal_d;
   logic             slot_free;
   logic             accept;

   // The output slot frees in the cycle it drains, giving back-to-back throughput.
   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = (state_q == EXEC_IDLE) && !flush && slot_free;
   assign accept    = in_valid && in_ready;

`ifdef CORE_EXEC_MUL_EN
   logic mul_wait;
   logic wd_timeout;

   assign mul_wait = (state_q == EXEC_MUL_WAIT);

   core_exec_watchdog #(
      .MUL_TIMEOUT (MUL_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_watchdog (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (mul_wait),
      .abort       (flush || mul_done),
      .timeout     (wd_timeout),
      .err_timeout (err_timeout)
   );

   assign mul_start = accept && (exec_engine == EXEC_MUL);
   // Kill on flush covers both an op already in the multiplier and one that would have started now.
   assign mul_kill  = wd_timeout ||
                      (flush && (mul_wait ||
                                 ((state_q == EXEC_IDLE) && slot_free && in_valid &&
                                  (exec_engine == EXEC_MUL))));
`else
   logic unused_mul;

   assign unused_mul  = ^{mul_done, mul_result, MUL_TIMEOUT[0], CNT_W[0]};
   assign mul_start   = 1'b0;
   assign mul_kill    = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      out_valid_d   = out_valid_q && !out_ready;
      out_result_d  = out_result_q;
      out_illegal_d = out_illegal_q;
      if (flush) begin
         state_d     = EXEC_IDLE;
         out_valid_d = 1'b0;
      end else if (accept) begin
         case (exec_engine)
            EXEC_ALU: begin
               out_valid_d   = 1'b1;
               out_result_d  = alu_result;
               out_illegal_d = 1'b0;
            end
`ifdef CORE_EXEC_MUL_EN
            EXEC_MUL: begin
               state_d     = EXEC_MUL_WAIT;
               out_valid_d = 1'b0;
            end
`endif
            default: begin
               out_valid_d   = 1'b1;
               out_result_d  = '0;
               out_illegal_d = 1'b1;
            end
         endcase
      end
`ifdef CORE_EXEC_MUL_EN
      else if (mul_wait && mul_done) begin
         state_d       = EXEC_IDLE;
         out_valid_d   = 1'b1;
         out_result_d  = mul_result;
         out_illegal_d = 1'b0;
      end else if (wd_timeout) begin
         state_d       = EXEC_IDLE;
         out_valid_d   = 1'b1;
         out_result_d  = '0;
         out_illegal_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= EXEC_IDLE;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= out_valid_d;
         out_result_q  <= out_result_d;
         out_illegal_q <= out_illegal_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_result  = out_result_q;
   assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_core_exec_ctrl.sv
// tb/tb_core_exec_ctrl.sv - directed self-checking bench for core_exec_ctrl
// Multiplier scenarios run when CORE_EXEC_MUL_EN is defined; otherwise EXEC_MUL is checked as illegal.
module tb_core_exec_ctrl;
   import core_pkg::*;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   exec_engine_e exec_engine;
   logic [31:0]  alu_result;
   logic         mul_start;
   logic         mul_kill;
   logic         mul_done;
   logic [31:0]  mul_result;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_result;
   logic         out_illegal;
   logic         err_timeout;

   int n_checks;
   int n_fail;

   core_exec_ctrl #(
      .MUL_TIMEOUT (8),
      .CNT_W       (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .exec_engine (exec_engine),
      .alu_result  (alu_result),
      .mul_start   (mul_start),
      .mul_kill    (mul_kill),
      .mul_done    (mul_done),
      .mul_result  (mul_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_illegal (out_illegal),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0; in_valid = 1'b0; exec_engine = EXEC_ALU; alu_result = '0;
      mul_done = 1'b0; mul_result = '0; out_ready = 1'b1;
      #3;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result got %h want 0", out_result); end
      n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_out_illegal got %b want 0", out_illegal); end
      n_checks++; if (mul_start !== 1'b0 || mul_kill !== 1'b0) begin n_fail++; $display("FAIL reset_mul_ctl got %b%b want 00", mul_start, mul_kill); end
      n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err_timeout got %b want 0", err_timeout); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; exec_engine = EXEC_ALU; alu_result = vals[i];
         #1;
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
         cyc();
         n_checks++; if (out_valid !== 1'b1 || out_result !== vals[i] || out_illegal !== 1'b0)
            begin n_fail++; $display("FAIL b2b_out[%0d] got v=%b r=%h i=%b want v=1 r=%h i=0", i, out_valid, out_result, out_illegal, vals[i]); end
      end
      in_valid = 1'b0;
      cyc();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
   endtask

   task automatic test_illegal();
      exec_engine_e bad [2];
      bad[0] = EXEC_LSU; bad[1] = EXEC_CSR;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; exec_engine = bad[i]; alu_result = 32'h77;
         #1;
         n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL illegal_mul_start[%0d] got %b want 0", i, mul_start); end
         cyc();
         in_valid = 1'b0;
         n_checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_result !== 32'h0)
            begin n_fail++; $display("FAIL illegal_out[%0d] got v=%b i=%b r=%h want v=1 i=1 r=0", i, out_valid, out_illegal, out_result); end
         cyc();
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; exec_engine = EXEC_ALU; alu_result = 32'h5A;
      cyc();
      alu_result = 32'h66;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
         n_checks++; if (out_valid !== 1'b1 || out_result !== 32'h5A)
            begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b r=%h want v=1 r=5a", i, out_valid, out_result); end
         cyc();
      end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
      cyc();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_result !== 32'h66)
         begin n_fail++; $display("FAIL bp_reload got v=%b r=%h want v=1 r=66", out_valid, out_result); end
      cyc();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_valid); end
   endtask

`ifdef CORE_EXEC_MUL_EN
   task automatic test_mul();
      int starts;
      starts = 0;
      out_ready = 1'b1;
      in_valid = 1'b1; exec_engine = EXEC_MUL;
      #1;
      if (mul_start === 1'b1) starts++;
      cyc();
      in_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         mul_done = (k == 4); mul_result = 32'hDEADBEEF;
         #1;
         if (mul_start === 1'b1) starts++;
         n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL mul_wait[%0d] got rdy=%b v=%b want 0 0", k, in_ready, out_valid); end
         cyc();
      end
      mul_done = 1'b0;
      n_checks++; if (starts !== 1) begin n_fail++; $display("FAIL mul_start_count got %0d want 1", starts); end
      n_checks++; if (out_valid !== 1'b1 || out_result !== 32'hDEADBEEF || out_illegal !== 1'b0)
         begin n_fail++; $display("FAIL mul_result got v=%b r=%h i=%b want v=1 r=deadbeef i=0", out_valid, out_result, out_illegal); end
      cyc();
   endtask

   task automatic test_flush();
      int kills;
      kills = 0;
      in_valid = 1'b1; exec_engine = EXEC_MUL;
      cyc();
      in_valid = 1'b0;
      cyc();
      flush = 1'b1;
      #1;
      if (mul_kill === 1'b1) kills++;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
      cyc();
      flush = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mul_done = (k == 1); mul_result = 32'hBAD0BAD0;
         #1;
         if (mul_kill === 1'b1) kills++;
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid[%0d] got %b want 0", k, out_valid); end
         cyc();
      end
      mul_done = 1'b0;
      n_checks++; if (kills !== 1) begin n_fail++; $display("FAIL flush_kill_count got %0d want 1", kills); end
      in_valid = 1'b1; exec_engine = EXEC_ALU; alu_result = 32'h42;
      cyc();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_result !== 32'h42)
         begin n_fail++; $display("FAIL flush_next_alu got v=%b r=%h want v=1 r=42", out_valid, out_result); end
      cyc();
   endtask

   task automatic test_watchdog();
      in_valid = 1'b1; exec_engine = EXEC_MUL;
      cyc();
      in_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         #1;
         n_checks++; if (mul_kill !== (k == 8)) begin n_fail++; $display("FAIL wd_kill[%0d] got %b want %b", k, mul_kill, (k == 8)); end
         n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_err_early[%0d] got %b want 0", k, err_timeout); end
         cyc();
      end
      n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_err got %b want 1", err_timeout); end
      n_checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_result !== 32'h0)
         begin n_fail++; $display("FAIL wd_out got v=%b i=%b r=%h want v=1 i=1 r=0", out_valid, out_illegal, out_result); end
      n_checks++; if (mul_kill !== 1'b0) begin n_fail++; $display("FAIL wd_kill_after got %b want 0", mul_kill); end
      repeat (4) cyc();
      n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_err_sticky got %b want 1", err_timeout); end
      test_reset();
      n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_err_cleared got %b want 0", err_timeout); end
   endtask
`else
   task automatic test_mul_disabled();
      out_ready = 1'b1;
      in_valid = 1'b1; exec_engine = EXEC_MUL; alu_result = 32'h99;
      mul_done = 1'b1; mul_result = 32'hDEADBEEF;
      #1;
      n_checks++; if (mul_start !== 1'b0 || mul_kill !== 1'b0) begin n_fail++; $display("FAIL nomul_ctl got %b%b want 00", mul_start, mul_kill); end
      cyc();
      in_valid = 1'b0; mul_done = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_result !== 32'h0)
         begin n_fail++; $display("FAIL nomul_out got v=%b i=%b r=%h want v=1 i=1 r=0", out_valid, out_illegal, out_result); end
      n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL nomul_err got %b want 0", err_timeout); end
      cyc();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nomul_drain got %b want 0", out_valid); end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      cyc();
      test_back_to_back();
      test_illegal();
      test_backpressure();
`ifdef CORE_EXEC_MUL_EN
      test_mul();
      test_flush();
      test_watchdog();
`else
      test_mul_disabled();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_exec_ctrl.md
Name: core_exec_ctrl

Overview:
- Execute-stage sequencer. Accepts one decoded operation per handshake and dispatches it to the single-cycle ALU or the multi-cycle multiplier according to exec_engine.
- Captures the selected result in an output register and presents it to writeback with a valid/ready handshake.
- Handles flush, multiplier kill and a multiplier watchdog.

Parameters:
- MUL_TIMEOUT, 64, max cycles from mul_start to mul_done before err_timeout is raised; range 2..255.
- CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > MUL_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill in-flight op and output; highest priority
- in_valid  in  1  decoded op available
- in_ready  out  1  op accepted when in_valid && in_ready
- exec_engine  in  core_pkg::exec_engine_e  engine select, sampled at accept
- alu_result  in  32  combinational ALU result for the current input op
- mul_start  out  1  one-cycle pulse starting the multiplier
- mul_kill  out  1  one-cycle pulse aborting the multiplier
- mul_done  in  1  one-cycle pulse, mul_result valid this cycle
- mul_result  in  32  multiplier result
- out_valid  out  1  result register valid
- out_ready  in  1  writeback accepts
- out_result  out  32  registered result
- out_illegal  out  1  qualifies out_valid: op was illegal, out_result = 0
- err_timeout  out  1  sticky watchdog error, cleared only by reset

Behaviour:
- Reset (async, rst_n low) values:
  - state = IDLE
  - out_valid = 0, out_result = 0, out_illegal = 0
  - mul_start = 0, mul_kill = 0
  - err_timeout = 0, watchdog counter = 0
- States: IDLE, MUL_WAIT.
- in_ready = (state == IDLE) && !flush && (!out_valid || out_ready). A slot frees in the same cycle it drains, so throughput is back-to-back.
- Accept with EXEC_ALU:
  - out_result <= alu_result, out_valid <= 1, out_illegal <= 0.
  - Latency: 1 cycle.
- Accept with EXEC_MUL:
  - mul_start = 1 combinationally in the accept cycle.
  - state <= MUL_WAIT, counter <= 0.
- Accept with any other encoding: out_valid <= 1, out_illegal <= 1, out_result <= 0.
- MUL_WAIT:
  - Counter increments each cycle.
  - On mul_done: out_result <= mul_result, out_valid <= 1, state <= IDLE. out_valid is guaranteed free on entry because accept required it.
  - Minimum MUL latency (accept to out_valid) = 2 cycles, when mul_done arrives the cycle after mul_start.
- mul_done in IDLE: ignored.
- Output hold: out_valid && !out_ready keeps out_result and out_illegal stable. out_valid drops after a handshake unless a new result loads in the same cycle.
- flush (synchronous):
  - Next cycle: out_valid = 0, state = IDLE, counter = 0.
  - In the flush cycle, if state is MUL_WAIT or a MUL accept would occur, mul_kill = 1.
  - No accept happens in a flush cycle.
  - mul_done coincident with flush is discarded.
- Watchdog: when counter reaches MUL_TIMEOUT in MUL_WAIT:
  - err_timeout <= 1 (sticky), mul_kill pulses.
  - out_valid <= 1 with out_illegal <= 1, state <= IDLE.
- mul_start and mul_kill are never asserted in the same cycle.
- Reset mid-MUL_WAIT: return to IDLE immediately, no mul_kill. The multiplier shares rst_n.

Optional Feature:
- Macro: CORE_EXEC_MUL_EN.
- Defined: behaviour as above.
- Undefined:
  - MUL_WAIT, the watchdog, mul_start and mul_kill logic are removed; mul_start and mul_kill are tied 0.
  - err_timeout is tied 0.
  - EXEC_MUL is treated as illegal (1-cycle out_illegal result).
  - mul_done and mul_result are unused.

Decomposition:
- core_pkg gains:
  - exec_ctrl_state_e {EXEC_IDLE, EXEC_MUL_WAIT}
  - default constant EXEC_MUL_TIMEOUT = 64
- exec_engine_e is reused unchanged.
- Natural sub-module: core_exec_watchdog (counter, compare, sticky error), instantiated only under CORE_EXEC_MUL_EN.

Test Plan:
- Back-to-back ALU: 3 ALU ops with out_ready = 1 and alu_result = 0x11, 0x22, 0x33 -> out_result 0x11, 0x22, 0x33 on consecutive cycles; in_ready stays 1.
- MUL: accept EXEC_MUL, mul_done 4 cycles after mul_start with mul_result = 0xDEADBEEF -> one mul_start pulse; in_ready = 0 during the wait; out_valid the cycle after mul_done with 0xDEADBEEF.
- Backpressure: ALU result 0x5A, out_ready = 0 for 5 cycles -> out_result held at 0x5A, in_ready = 0; releasing out_ready with in_valid high -> next op loads in the same cycle.
- Flush during MUL_WAIT at cycle 2 -> mul_kill pulses once, out_valid stays 0; a later mul_done is ignored; next ALU op completes normally.
- Watchdog: MUL with mul_done never asserted, MUL_TIMEOUT = 8 -> err_timeout = 1 and mul_kill pulse 8 cycles after accept; out_valid with out_illegal = 1; err_timeout stays set until reset.
- Illegal engine encoding, and EXEC_MUL with CORE_EXEC_MUL_EN undefined -> out_illegal = 1, out_result = 0, latency 1; mul_start never asserted.
